// File: rtl/cmul_pkg.sv
// Shared widths, saturation limits and depth limits for the complex multiplier.
package cmul_pkg;

    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

    function automatic int sum_w(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int payload_w(input int n, input int tag_w);
        return 4 * prod_w(n) + 1 + tag_w;
    endfunction

    function automatic logic signed [64:0] sat_max(input int n);
        return (65'sd1 <<< (n - 1)) - 65'sd1;
    endfunction

    function automatic logic signed [64:0] sat_min(input int n);
        return -(65'sd1 <<< (n - 1));
    endfunction

endpackage

// File: rtl/cmul_stage_reg.sv
// One enable-gated pipeline slot: valid bit plus payload, moving together.
module cmul_stage_reg
    import cmul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/complex_mult_pipe.sv
// Pipelined fixed-point complex multiplier, a*b or a*conj(b), with tag.
// Define COMPLEX_MULT_SAT_EN to saturate results instead of wrapping.
module complex_mult_pipe
    import cmul_pkg::*;
#(
    parameter int N      = 32,
    parameter int D      = 16,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recv_val,
    output logic             recv_rdy,
    input  logic [N-1:0]     ar,
    input  logic [N-1:0]     ac,
    input  logic [N-1:0]     br,
    input  logic [N-1:0]     bc,
    input  logic             conj_b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             send_val,
    input  logic             send_rdy,
    output logic [N-1:0]     cr,
    output logic [N-1:0]     cc,
    output logic [TAG_W-1:0] tag_out
);

    localparam int PW = prod_w(N);
    localparam int SW = sum_w(N);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("complex_mult_pipe: STAGES out of range");
    end

    typedef struct packed {
        logic signed [PW-1:0] rr;
        logic signed [PW-1:0] ii;
        logic signed [PW-1:0] ri;
        logic signed [PW-1:0] ir;
        logic                 conj;
        logic [TAG_W-1:0]     tag;
    } prod_t;

    logic  adv;
    logic  v [STAGES];
    prod_t d [STAGES];
    prod_t p_in;
    prod_t q;

    assign adv      = send_rdy || !send_val;
    assign recv_rdy = adv;

    // Raw products only; the conjugate sign is applied when summing so
    // bc = -2^(N-1) never needs an N-bit negation.
    always_comb begin
        p_in      = '0;
        p_in.rr   = PW'($signed(ar)) * PW'($signed(br));
        p_in.ii   = PW'($signed(ac)) * PW'($signed(bc));
        p_in.ri   = PW'($signed(ar)) * PW'($signed(bc));
        p_in.ir   = PW'($signed(ac)) * PW'($signed(br));
        p_in.conj = conj_b;
        p_in.tag  = tag_in;
    end

    assign v[0] = recv_val;
    assign d[0] = p_in;

    for (genvar i = 1; i < STAGES; i++) begin : g_stage
        cmul_stage_reg #(
            .W($bits(prod_t))
        ) u_reg (
            .clk      (clk),
            .reset    (reset),
            .en       (adv),
            .in_valid (v[i-1]),
            .in_data  (d[i-1]),
            .out_valid(v[i]),
            .out_data (d[i])
        );
    end

    assign q = d[STAGES-1];

    logic signed [SW-1:0] sum_r;
    logic signed [SW-1:0] sum_i;

    always_comb begin
        sum_r = SW'(q.rr) - SW'(q.ii);
        sum_i = SW'(q.ri) + SW'(q.ir);
        if (q.conj) begin
            sum_r = SW'(q.rr) + SW'(q.ii);
            sum_i = SW'(q.ir) - SW'(q.ri);
        end
    end

    function automatic logic [N-1:0] reduce(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] sh;
`ifdef COMPLEX_MULT_SAT_EN
        logic signed [64:0] x;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
`endif
        sh = s >>> D;
`ifdef COMPLEX_MULT_SAT_EN
        x  = 65'(sh);
        hi = sat_max(N);
        lo = sat_min(N);
        if (x > hi) begin
            x = hi;
        end else if (x < lo) begin
            x = lo;
        end
        return x[N-1:0];
`else
        return sh[N-1:0];
`endif
    endfunction

    // Data only loads with a valid item so outputs keep their last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            send_val <= 1'b0;
            cr       <= '0;
            cc       <= '0;
            tag_out  <= '0;
        end else if (adv) begin
            send_val <= v[STAGES-1];
            if (v[STAGES-1]) begin
                cr      <= reduce(sum_r);
                cc      <= reduce(sum_i);
                tag_out <= q.tag;
            end
        end
    end

endmodule

// File: doc/complex_mult_pipe.md
COMPLEX_MULT_PIPE -- requirements
Module: complex_mult_pipe

Interface
REQ-001 Parameter N, default 32: operand/result bit width, signed two's complement, 4..32.
REQ-002 Parameter D, default 16: fractional bits, 0..N-1.
REQ-003 Parameter STAGES, default 2: pipeline depth in register stages, 1..4.
REQ-004 Parameter TAG_W, default 4: width of the pass-through transaction tag, at least 1.
REQ-005 clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 recv_val  in  1 / recv_rdy  out  1: input handshake.
REQ-008 ar, ac, br, bc  in  N each: real/imag parts of operands a, b.
REQ-009 conj_b  in  1: when 1, multiply by conjugate of b.
REQ-010 tag_in  in  TAG_W: opaque tag travelling with the operands.
REQ-011 send_val  out  1 / send_rdy  in  1: output handshake.
REQ-012 cr, cc  out  N each: real/imag result; tag_out  out  TAG_W.

Function
REQ-013 Transfer occurs on a rising edge where val and rdy are both 1, per interface.
REQ-014 Result SHALL equal a*b (or a*conj(b) if conj_b): cr = ar*br - ac*bc', cc = ar*bc' + ac*br, with bc' = -bc when conj_b else bc.
REQ-015 Four signed NxN->2N products SHALL be formed; sums at 2N+1 bits; result = sum arithmetically shifted right by D (truncation toward minus infinity), then reduced to N bits per REQ-027/028.
REQ-016 Negation of bc SHALL be done at 2N-bit product level so bc = -2^(N-1) is exact.
REQ-017 Latency SHALL be exactly STAGES cycles: an item accepted at edge k presents send_val=1 after edge k+STAGES, absent stalls.
REQ-018 Each stage SHALL hold a valid bit; data/tag/conj move together with it.
REQ-019 Pipeline SHALL advance when send_rdy=1 or last-stage valid=0; recv_rdy SHALL equal that advance condition (full throughput, one item per cycle).
REQ-020 On stall (send_val=1, send_rdy=0) all stages SHALL hold; cr, cc, tag_out SHALL stay stable.
REQ-021 Bubbles SHALL NOT be compressed during a stall; no item is lost or duplicated.
REQ-022 Simultaneous output drain and input accept in the same cycle SHALL be supported with no bubble.
REQ-023 Tag_out SHALL equal the tag_in captured with the same item; ordering SHALL be FIFO.
REQ-024 With STAGES=1 products and sums are combinational into one output register; with STAGES>=2 stage 1 registers the four products, the last stage registers the final result, intermediate stages are pure delay.

Reset
REQ-025 reset SHALL clear every valid bit; send_val=0 the cycle after reset is sampled; recv_rdy=1 while out of reset and empty.
REQ-026 reset mid-operation SHALL discard all in-flight items; cr, cc, tag_out SHALL read 0 after reset.

Configuration
REQ-027 With macro COMPLEX_MULT_SAT_EN defined, each result SHALL saturate to [-2^(N-1), 2^(N-1)-1] after the shift.
REQ-028 Without COMPLEX_MULT_SAT_EN, results SHALL wrap (low N bits of shifted sum).

Structure
REQ-029 Package cmul_pkg SHALL hold the stage payload struct type helpers, SAT_MAX/SAT_MIN constant functions of N, and the STAGES range limits.
REQ-030 One sub-module cmul_stage_reg SHALL implement a single enable-gated valid+payload register; the pipeline instantiates STAGES-1 of them plus the result stage.

Verification (N=16, D=8, STAGES=2)
REQ-031 a=(0x0180,0x0200), b=(0x0080,0xFF00), conj_b=0 -> cr=0x02C0, cc=0xFF80, send_val exactly 2 cycles after accept.
REQ-032 Same operands, conj_b=1 -> cr=0xFEC0, cc=0x0280.
REQ-033 a=(0x7F00,0), b=(0x0200,0) -> cr=0xFE00 without macro, 0x7FFF with COMPLEX_MULT_SAT_EN; cc=0.
REQ-034 Stream 8 back-to-back items, tags 0..7, send_rdy low cycles 3-5 -> all 8 out in order, tags intact, outputs stable while stalled, recv_rdy low during stall once full.
REQ-035 Reset asserted with 2 items in flight -> no send_val after reset; next item produces correct result at normal latency.
REQ-036 Random 10k items vs. golden model, random val/rdy, both macro settings, STAGES 1..4 -> zero mismatches.
